rgb_palette: RTL

Programmable, parametrised colour palette for the display path: converts a colour index into a packed RGB word through a register-based lookup table. It extends the fixed eight-entry colour ROM with run-time rewritable entries, configurable depth and channel width, a valid flag, and an autonomous colour-cycle mode for demo/test patterns. It sits between the colour-select logic and the pixel/LED driver.

---
 rtl/rgb_pkg.sv | 43 ++++
 rtl/rgb_cycle_ctrl.sv | 47 ++++
 rtl/rgb_palette.sv | 101 ++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB palette block: channel width default,
// named colour indices and the function that builds the reset palette.
// No logic here; everything is elaboration-time constants.
package rgb_pkg;

  // Default bits per colour channel; the RGB word is three channels wide.
  localparam int CH_W_DEFAULT = 8;

  // Widest channel the default-entry builder supports. Callers cast the
  // result down to their own 3*CH_W word.
  localparam int MAX_CH_W = 32;

  // Named indices of the eight base colours (bit2=R, bit1=G, bit0=B).
  localparam logic [2:0] COL_BLACK   = 3'd0;
  localparam logic [2:0] COL_BLUE    = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_CYAN    = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;
  localparam logic [2:0] COL_YELLOW  = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

  // Reset value of palette entry idx for a given channel width, packed
  // {R,G,B} in the low 3*ch_w bits. Only idx[2:0] matters, so entries
  // beyond 7 repeat the eight-colour pattern.
  function automatic logic [3*MAX_CH_W-1:0] default_entry(
    input int unsigned idx,
    input int unsigned ch_w
  );
    logic [3*MAX_CH_W-1:0] ones;
    logic [3*MAX_CH_W-1:0] word;
    ones = '0;
    for (int k = 0; k < MAX_CH_W; k++) begin
      if (k < int'(ch_w)) ones[k] = 1'b1;
    end
    word = '0;
    if (idx[2]) word = word | (ones << (2 * ch_w));
    if (idx[1]) word = word | (ones << ch_w);
    if (idx[0]) word = word | ones;
    return word;
  endfunction

endpackage

// File: rtl/rgb_cycle_ctrl.sv
// Colour-cycle sequencer: prescaler plus wrapping palette index.
// Latency: cycle_idx is registered and steps one edge after the prescaler terminal count.
// No backpressure: free-running while cycle_en=1, cleared when cycle_en=0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cycle_en   run the sequencer; low clears prescaler and index
//   cycle_idx  current palette index, 0..DEPTH-1
module rgb_cycle_ctrl
  import rgb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PERIOD = 50_000_000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cycle_en,
  output logic [ADDR_W-1:0] cycle_idx
);

  // PERIOD=1 still needs a one-bit counter; it simply stays at zero and
  // the terminal-count compare is true every cycle.
  localparam int PRE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PERIOD - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  logic [PRE_W-1:0] prescaler;
  logic             step;

  assign step = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || !cycle_en) begin
      prescaler <= '0;
      cycle_idx <= '0;
    end else if (step) begin
      prescaler <= '0;
      // Explicit wrap so non-power-of-two depths never index past the end.
      cycle_idx <= (cycle_idx == IDX_LAST) ? '0 : cycle_idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_palette.sv
// Programmable colour palette: colour index -> registered {R,G,B} word.
// Latency: 1 cycle from read request (enable or cycle mode) to rgb/rgb_valid.
// No backpressure: every request is serviced; rgb holds when nothing is read.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   enable, colour     read request and index (ignored while cycle_en=1)
//   wr_en, wr_addr,    palette write; out-of-range addresses are dropped
//   wr_data
//   cycle_en           autonomous colour-cycle mode, reads every cycle
//   rgb, rgb_valid     registered read data and "read this cycle" flag
//   cycle_idx          current cycle-mode index
module rgb_palette
  import rgb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CH_W   = CH_W_DEFAULT,
  parameter int PERIOD = 50_000_000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   colour,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                cycle_en,
  output logic [3*CH_W-1:0]   rgb,
  output logic                rgb_valid,
  output logic [ADDR_W-1:0]   cycle_idx
);

  localparam int RGB_W = 3 * CH_W;

  logic [RGB_W-1:0]  mem [DEPTH];

  logic              wr_ok;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_in_range;
  logic              rd_bypass;
  logic [RGB_W-1:0]  rd_data;

  // ---------------------------------------------------------------------
  // Cycle-mode index generator
  // ---------------------------------------------------------------------
  rgb_cycle_ctrl #(
    .DEPTH  (DEPTH),
    .PERIOD (PERIOD),
    .ADDR_W (ADDR_W)
  ) u_cycle (
    .clk       (clk),
    .rst       (rst),
    .cycle_en  (cycle_en),
    .cycle_idx (cycle_idx)
  );

  // ---------------------------------------------------------------------
  // Read source select and write-first bypass
  // ---------------------------------------------------------------------
  // Range checks are done at 32 bits so a power-of-two DEPTH does not
  // produce a constant-true compare at ADDR_W bits.
  assign wr_ok       = wr_en && (32'(wr_addr) < DEPTH);
  assign rd_req      = cycle_en || enable;
  assign rd_idx      = cycle_en ? cycle_idx : colour;
  assign rd_in_range = (32'(rd_idx) < DEPTH);
  // A write landing on the entry being read this edge wins, so the
  // output reflects the new value immediately.
  assign rd_bypass   = wr_ok && (wr_addr == rd_idx);

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = rd_bypass ? wr_data : mem[rd_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Palette storage and output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset reloads the base colours and beats any write in flight.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RGB_W'(default_entry(i, CH_W));
      end
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      rgb_valid <= rd_req;
      if (rd_req) begin
        rgb <= rd_data;
      end
    end
  end

endmodule
